fp_mul_pipe: RTL and testbench
==============================

// Module: fp_mul_pipe
// PURPOSE
//  Parametrised, pipelined IEEE-754-format floating-point multiplier with valid/ready handshake.
//  Successor to the combinational single-precision multiply wrapper:
//   - keeps the +-1.0 and zero fast paths, now with the correct sign rule;
//   - adds configurable exponent/mantissa widths, pipeline depth and status flags.
//  Sits between the matrix-element fetch logic and the divider/accumulator datapath.
// PARAMETERS
//  EXP_W   8   exponent width; BIAS = 2**(EXP_W-1)-1
//  MAN_W   23  stored mantissa width; word width W = 1+EXP_W+MAN_W
//  STAGES  3   pipeline depth, >=1; fixed latency in accepted-to-presented cycles
//  FAST_EN 1   1: +-1.0/zero operands skip the product path (result still rides the pipe)
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  operand pair valid
//  in_ready   out  1  block can accept operands this cycle
//  in1, in2   in   W  operands {sign, exp, mantissa}
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer accepts result
//  result     out  W  product
//  overflow   out  1  result saturated to infinity
//  underflow  out  1  result flushed to zero, non-zero operands
//  exception  out  1  an operand was Inf or NaN
// BEHAVIOUR
//  Reset: all stage valids=0; out_valid=0; result=0; all flags=0; in_ready=1 on the first cycle after reset.
//  Handshake:
//   - accept when in_valid&&in_ready; present when out_valid; retire when out_valid&&out_ready.
//   - stall = out_valid&&!out_ready; in_ready = !stall.
//   - A stall freezes every stage.
//   - Bubbles are not compressed: an empty stage is not filled while the pipe is stalled.
//   - result and flags are stable while out_valid&&!out_ready.
//  Latency: a pair accepted at cycle t is presented at t+STAGES with no stalls; results stay in order.
//  Throughput: 1 pair per cycle.
//  Sign: s = in1.sign ^ in2.sign in all cases.
//  Priority, highest first:
//   1. Either exp all-ones (Inf/NaN): result = canonical NaN {0, all-ones exp, 1 in mantissa MSB, zeros}; exception=1.
//   2. Either operand exp==0 (zero or subnormal, flushed): result = {s, zeros}; no flags.
//   3. FAST_EN and either operand magnitude == 1.0 (exp==BIAS, man==0): result = {s, other operand[W-2:0]}.
//   4. General path:
//      - mantissas {1,man} multiplied to a 2*(MAN_W+1)-bit product;
//      - normalise by 1 if the product MSB is set; truncate (round toward zero);
//      - exponent = e1+e2-BIAS+norm, computed in EXP_W+2 signed bits.
//   5. Exponent >= 2**EXP_W-1: result = {s, all-ones exp, zeros} (infinity); overflow=1.
//   6. Exponent <= 0: result = {s, zeros}; underflow=1.
//  Pipeline split:
//   - stage 1: classify and unpack;
//   - middle stages: product (split across stages when STAGES>2);
//   - last stage: normalise and pack.
//   - STAGES=1: one registered combinational path.
//  rst mid-operation: all in-flight pairs are discarded; no result is presented for them.
//  Simultaneous retire and accept under full occupancy is legal and loses nothing.
// TESTING
//  T1 0x40000000*0x40400000 (2*3), out_ready=1 -> 0x40C00000 after exactly 3 cycles, flags 0.
//  T2 0xBF800000*0x40200000 (-1*2.5) -> 0xC0200000; 0x3FC00000*0x3FC00000 (1.5*1.5) -> 0x40100000.
//  T3 0x7F000000*0x7F000000 -> 0x7F800000, overflow=1; 0x00800000*0x00800000 -> 0x00000000, underflow=1.
//  T4 0x7FC00000*0x3F800000 -> 0x7FC00000, exception=1 (NaN outranks the 1.0 fast path);
//     0x80000000*0x40000000 -> 0x80000000.
//  T5 Stream 8 back-to-back pairs; hold out_ready=0 for cycles 4..9 ->
//     in_ready=0 while stalled; all 8 results in order; none dropped or duplicated.
//  T6 Assert rst with 2 pairs in flight -> out_valid=0 the next cycle; no stale results afterwards.
//     Repeat T1 with STAGES=1 -> result after 1 cycle.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: pipelined IEEE-754-format multiplier with a valid/ready handshake.
// Stage 1 classifies and unpacks the operands. The middle stages form the
// mantissa product, split into two partial-product steps when there is room.
// The last stage normalises, packs and registers the result and status flags.
// Subnormals are flushed to zero and the product is truncated (round toward zero).
module fp_mul_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int STAGES  = 3,
  parameter int FAST_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in1,
  input  logic [EXP_W+MAN_W:0]   in2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   exception
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int MW   = MAN_W + 1;              // mantissa including the hidden bit
  localparam int PW   = 2 * MW;                 // full product width
  localparam int EW   = EXP_W + 2;              // signed working exponent width
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int MAXE = (1 << EXP_W) - 1;       // all-ones exponent (Inf/NaN code)
  localparam int LO_W = MW / 2;                 // split point of the two-step product

  // Operand class decided in stage 1; it picks which result the pack stage emits.
  typedef enum logic [1:0] {
    C_NAN  = 2'd0,
    C_ZERO = 2'd1,
    C_FAST = 2'd2,
    C_GEN  = 2'd3
  } cls_t;

  // Everything a pair needs on its way down the pipe.
  typedef struct packed {
    logic          s;
    cls_t          cls;
    logic [W-2:0]  fmag;   // magnitude passed through on the +-1.0 fast path
    logic [EW-1:0] esum;   // e1+e2-BIAS, two's complement
    logic [MW-1:0] m1;
    logic [MW-1:0] m2;
    logic [PW-1:0] prod;
  } pipe_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         unf;
    logic         exc;
  } out_t;

  // Classify the operands and split them into sign, exponent sum and mantissas.
  function automatic pipe_t f_unpack(input logic [W-1:0] a, input logic [W-1:0] b);
    pipe_t            p;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    ea     = a[W-2:MAN_W];
    eb     = b[W-2:MAN_W];
    ma     = a[MAN_W-1:0];
    mb     = b[MAN_W-1:0];
    p      = '0;
    p.cls  = C_GEN;
    p.s    = a[W-1] ^ b[W-1];
    p.esum = EW'(ea) + EW'(eb) - EW'(BIAS);
    p.m1   = {1'b1, ma};
    p.m2   = {1'b1, mb};
    // Inf/NaN outranks zero, which outranks the +-1.0 shortcut.
    if (&ea || &eb) begin
      p.cls = C_NAN;
    end else if (ea == '0 || eb == '0) begin
      p.cls = C_ZERO;
    end else if (FAST_EN != 0 && ea == EXP_W'(BIAS) && ma == '0) begin
      p.cls  = C_FAST;
      p.fmag = b[W-2:0];
    end else if (FAST_EN != 0 && eb == EXP_W'(BIAS) && mb == '0) begin
      p.cls  = C_FAST;
      p.fmag = a[W-2:0];
    end
    return p;
  endfunction

  // Full mantissa product in one step.
  function automatic pipe_t f_mul_full(input pipe_t pi);
    pipe_t p;
    p      = pi;
    p.prod = PW'(pi.m1) * PW'(pi.m2);
    return p;
  endfunction

  // First half of a split product: m1 times the low half of m2.
  function automatic pipe_t f_mul_lo(input pipe_t pi);
    pipe_t p;
    p      = pi;
    p.prod = PW'(pi.m1) * PW'(pi.m2[LO_W-1:0]);
    return p;
  endfunction

  // Second half: add m1 times the high half of m2, shifted into place.
  function automatic pipe_t f_mul_hi(input pipe_t pi);
    pipe_t p;
    p      = pi;
    p.prod = pi.prod + ((PW'(pi.m1) * PW'(pi.m2[MW-1:LO_W])) << LO_W);
    return p;
  endfunction

  // Normalise by at most one place, truncate, range-check and pack.
  function automatic out_t f_pack(input pipe_t p);
    out_t             o;
    logic             norm;
    logic [EW-1:0]    e;
    logic [MAN_W-1:0] man;
    o    = '0;
    norm = p.prod[PW-1];
    man  = norm ? p.prod[PW-2 -: MAN_W] : p.prod[PW-3 -: MAN_W];
    e    = p.esum + EW'(norm);
    case (p.cls)
      C_NAN: begin
        o.res[W-2:MAN_W] = '1;
        o.res[MAN_W-1]   = 1'b1;
        o.exc            = 1'b1;
      end
      C_ZERO: o.res[W-1] = p.s;
      C_FAST: o.res      = {p.s, p.fmag};
      default: begin
        if ($signed(e) >= $signed(EW'(MAXE))) begin
          o.res[W-1]       = p.s;
          o.res[W-2:MAN_W] = '1;
          o.ovf            = 1'b1;
        end else if ($signed(e) <= 0) begin
          o.res[W-1] = p.s;
          o.unf      = 1'b1;
        end else begin
          o.res = {p.s, e[EXP_W-1:0], man};
        end
      end
    endcase
    return o;
  endfunction

  logic [STAGES:1] r_vld_pipe;
  logic [STAGES:0] w_vin;      // valid entering each register, bit 0 = input port
  logic            w_stall;
  pipe_t           w_last;     // data entering the pack stage
  out_t            r_out;

  assign w_stall   = r_vld_pipe[STAGES] && !out_ready;
  assign in_ready  = !w_stall;
  assign w_vin     = {r_vld_pipe, in_valid};
  assign out_valid = r_vld_pipe[STAGES];
  assign result    = r_out.res;
  assign overflow  = r_out.ovf;
  assign underflow = r_out.unf;
  assign exception = r_out.exc;

  generate
    if (STAGES == 1) begin : g_s1
      assign w_last = f_mul_full(f_unpack(in1, in2));
    end else begin : g_sn
      pipe_t r_d [1:STAGES-1];

      // Data stages advance together with the valid bits; a stall freezes them all.
      always_ff @(posedge clk) begin
        if (!w_stall) begin
          r_d[1] <= f_unpack(in1, in2);
          for (int k = 2; k < STAGES; k++) begin
            if (STAGES == 3)  r_d[k] <= f_mul_full(r_d[k-1]);
            else if (k == 2)  r_d[k] <= f_mul_lo(r_d[k-1]);
            else if (k == 3)  r_d[k] <= f_mul_hi(r_d[k-1]);
            else              r_d[k] <= r_d[k-1];
          end
        end
      end

      if (STAGES == 2) begin : g_mul_last
        assign w_last = f_mul_full(r_d[1]);
      end else begin : g_mul_mid
        assign w_last = r_d[STAGES-1];
      end
    end
  endgenerate

  // Valid shift register and output register; output only reloads when a pair arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_out      <= '0;
    end else if (!w_stall) begin
      r_vld_pipe <= w_vin[STAGES-1:0];
      if (w_vin[STAGES-1]) r_out <= f_pack(w_last);
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: scoreboard queue filled at accept time, drained by a
// monitor on the falling edge. A second single-stage instance checks latency 1.
module tb_fp_mul_pipe;

  localparam int STG = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in1, in2, result;
  logic        overflow, underflow, exception;

  logic        d1_in_valid, d1_in_ready, d1_out_valid;
  logic [31:0] d1_in1, d1_in2, d1_result;
  logic        d1_ovf, d1_unf, d1_exc;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    logic        o, u, x;
    bit          lat;
    int          acc;
  } exp_t;
  exp_t sbq[$];

  logic        stl_prev = 1'b0;
  logic [34:0] stl_val;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(STG), .FAST_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow), .exception(exception)
  );

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(1), .FAST_EN(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .in1(d1_in1), .in2(d1_in2), .out_valid(d1_out_valid), .out_ready(1'b1),
    .result(d1_result), .overflow(d1_ovf), .underflow(d1_unf), .exception(d1_exc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  // Present a pair, wait (bounded) for acceptance, and record the expected response.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                      input logic o, input logic u, input logic x, input bit lat);
    int   n;
    exp_t e;
    in1 = a; in2 = b; in_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=in_ready_low expected=accepted");
    end else begin
      e.res = r; e.o = o; e.u = u; e.x = x; e.lat = lat; e.acc = cyc;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
    #1;
  endtask

  // Monitor: compare every retired result against the scoreboard; check stall behaviour.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output actual=%h expected=none", result);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("result_flags", 64'({result, overflow, underflow, exception}),
              64'({e.res, e.o, e.u, e.x}));
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(STG));
        end
      end
      if (out_valid && !out_ready) begin
        chk("in_ready_stall", 64'(in_ready), 64'd0);
        if (stl_prev) chk("stall_stable", 64'({result, overflow, underflow, exception}),
                          64'(stl_val));
        stl_prev = 1'b1;
        stl_val  = {result, overflow, underflow, exception};
      end else begin
        stl_prev = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in1 = '0; in2 = '0;
    d1_in_valid = 1'b0; d1_in1 = '0; d1_in2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result",    64'(result),    64'd0);
    chk("rst_flags",     64'({overflow, underflow, exception}), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_d1_valid",  64'(d1_out_valid), 64'd0);
    chk("rst_d1_result", 64'(d1_result), 64'd0);
    @(posedge clk); #1;

    // T1: 2*3
    send(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0, 1);
    drain();

    // T2..T4 back to back: fast path, normalise, overflow, underflow, NaN priority, signed zero
    send(32'hBF800000, 32'h40200000, 32'hC0200000, 0, 0, 0, 1);
    send(32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0, 0, 1);
    send(32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0, 0, 1);
    send(32'h00800000, 32'h00800000, 32'h00000000, 0, 1, 0, 1);
    send(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 0, 1, 1);
    send(32'h80000000, 32'h40000000, 32'h80000000, 0, 0, 0, 1);
    send(32'hFF800000, 32'h00000000, 32'h7FC00000, 0, 0, 1, 1);
    drain();

    // T5: 8 back-to-back pairs with out_ready low for cycles 4..9
    fork
      begin
        send(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0, 0);
        send(32'hBF800000, 32'h40200000, 32'hC0200000, 0, 0, 0, 0);
        send(32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0, 0, 0);
        send(32'h40400000, 32'h40400000, 32'h41100000, 0, 0, 0, 0);
        send(32'h3F000000, 32'h3F000000, 32'h3E800000, 0, 0, 0, 0);
        send(32'h40000000, 32'hC0800000, 32'hC1000000, 0, 0, 0, 0);
        send(32'h3F800000, 32'h40E00000, 32'h40E00000, 0, 0, 0, 0);
        send(32'h41200000, 32'h41200000, 32'h42C80000, 0, 0, 0, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // T6: reset with two pairs in flight; nothing may come out afterwards
    send(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0, 0);
    send(32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0, 0, 0);
    rst = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    chk("rst_flush_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(out_valid), 64'd0);

    send(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0, 1);
    drain();

    // single-stage instance: result one cycle after acceptance
    d1_in1 = 32'h40000000; d1_in2 = 32'h40400000; d1_in_valid = 1'b1;
    @(negedge clk);
    chk("d1_in_ready", 64'(d1_in_ready), 64'd1);
    @(posedge clk);
    #1 d1_in_valid = 1'b0;
    @(negedge clk);
    chk("d1_out_valid", 64'(d1_out_valid), 64'd1);
    chk("d1_result", 64'({d1_result, d1_ovf, d1_unf, d1_exc}), 64'({32'h40C00000, 3'b000}));
    @(negedge clk);
    chk("d1_retired", 64'(d1_out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
